// File: rtl/tdm_mux_8x1_pkg.sv
// Shared definitions for the 8-channel TDM collector and its demultiplexer counterpart.
// The channel-index type doubles as the demux select so both sides agree on encoding.
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef logic [CH_W-1:0] ch_idx_t;

  // Channel index 'off' positions after 'base', wrapping 7 -> 0.
  function automatic ch_idx_t ch_offset(ch_idx_t base, int off);
    return base + ch_idx_t'(off);
  endfunction

endpackage

// File: rtl/tdm_mux_8x1_if.sv
// Bundle of per-channel input handshakes and the serialized tagged output stream.
// slave is the collector side, master is whoever feeds sources and sinks the stream.
interface tdm_mux_8x1_if #(parameter int DATA_W = 8);
  import tdm_pkg::*;

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  ch_idx_t                  out_sel;
  logic                     out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/tdm_mux_8x1_rr_arbiter.sv
// Round-robin arbiter over the eight holding-register full flags.
// The pointer only moves when a grant is actually taken by the output register.
module rr_arbiter_8
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant_oh,
  output ch_idx_t           grant_idx,
  output logic              grant_valid
);

  ch_idx_t last_grant;

  // Search starts one past the last winner; offset NUM_CH revisits last_grant itself.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!grant_valid && req[ch_offset(last_grant, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = ch_offset(last_grant, k);
      end
    end
  end

  assign grant_oh = grant_valid ? (NUM_CH'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ch_idx_t'(NUM_CH - 1);
    end else if (advance && grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/tdm_mux_8x1.sv
// Eight-channel time-division collector: one holding register per channel, a
// round-robin pick among full channels, and a tagged valid/ready output register.
module tdm_mux_8x1
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8
)
(
  input  logic          clk,
  input  logic          rst_n,
  tdm_mux_8x1_if.slave  bus
);

  logic [NUM_CH-1:0] full;
  logic [DATA_W-1:0] hold_data [NUM_CH];
  logic              load;
  logic [NUM_CH-1:0] grant_oh;
  ch_idx_t           grant_idx;
  logic              grant_valid;

  assign bus.in_ready = ~full;
  assign load         = !bus.out_valid || bus.out_ready;

  rr_arbiter_8 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (full),
    .advance     (load),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A granted channel is never ready in the same cycle, so release always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load && grant_oh[i]) begin
          full[i] <= 1'b0;
        end else if (bus.in_valid[i] && !full[i]) begin
          full[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.in_valid[i] && !full[i]) begin
        hold_data[i] <= bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Data and tag only change on a grant, which keeps them stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
    end else if (load) begin
      bus.out_valid <= grant_valid;
      if (grant_valid) begin
        bus.out_data <= hold_data[grant_idx];
        bus.out_sel  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Scenario bench for tdm_mux_8x1: expected {sel,data} words are queued when driven
// and popped when the collector presents them on the output.
module tb_tdm_mux_8x1;
  import tdm_pkg::*;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } item_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  item_t sb[$];
  item_t exp_item;
  int    errors = 0;
  int    checks = 0;
  bit    ok;

  tdm_mux_8x1_if #(.DATA_W(8)) bus ();

  tdm_mux_8x1 #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_handshake(input int budget, output bit hit);
    hit = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel} !== {8'hFF, 1'b0, 8'h00, 3'd0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got ready=%h valid=%b data=%h sel=%0d, expected ff 0 00 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 8'h08;
    bus.in_data[3*8 +: 8] = 8'hA5;
    sb.push_back(item_t'{3'd3, 8'hA5});
    @(negedge clk);
    bus.in_valid = '0;
    checks++;
    if (bus.in_ready !== 8'hF7 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got ready=%h valid=%b, expected f7 0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    exp_item = sb.pop_front();
    if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== exp_item || bus.in_ready !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL reset_first_word: got valid=%b sel=%0d data=%h ready=%h, expected 1 %0d %h ff",
               bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready, exp_item.sel, exp_item.data);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_drain: got valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.in_valid = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      bus.in_data[i*8 +: 8] = 8'(8'h10 + i);
      sb.push_back(item_t'{3'(i), 8'(8'h10 + i)});
    end
    @(negedge clk);
    bus.in_valid = '0;
    checks++;
    if (bus.in_ready !== 8'h00 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rr_fill: got ready=%h valid=%b, expected 00 0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      exp_item = sb.pop_front();
      if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== exp_item) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: got valid=%b sel=%0d data=%h, expected 1 %0d %h",
                 i, bus.out_valid, bus.out_sel, bus.out_data, exp_item.sel, exp_item.data);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL rr_ninth: got valid=%b ready=%h, expected 0 ff", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid = 8'h24;
    bus.in_data[2*8 +: 8] = 8'h22;
    bus.in_data[5*8 +: 8] = 8'h55;
    sb.push_back(item_t'{3'd2, 8'h22});
    sb.push_back(item_t'{3'd5, 8'h55});
    @(negedge clk);
    bus.in_valid = '0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd2, 8'h22} || bus.in_ready[5] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b sel=%0d data=%h ready5=%b, expected 1 2 22 0",
                 c, bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready[5]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      checks++;
      exp_item = sb.pop_front();
      if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== exp_item) begin
        errors++;
        $display("[TB] FAIL bp_release[%0d]: got valid=%b sel=%0d data=%h, expected 1 %0d %h",
                 n, bus.out_valid, bus.out_sel, bus.out_data, exp_item.sel, exp_item.data);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_empty: got valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    bus.in_valid = 8'h40;
    bus.in_data[6*8 +: 8] = 8'h66;
    sb.push_back(item_t'{3'd6, 8'h66});
    @(negedge clk);
    bus.in_valid = '0;
    for (int n = 0; n < 3; n++) begin
      if (n == 1) begin
        bus.in_valid = 8'h82;
        bus.in_data[1*8 +: 8] = 8'h11;
        bus.in_data[7*8 +: 8] = 8'h77;
        sb.push_back(item_t'{3'd7, 8'h77});
        sb.push_back(item_t'{3'd1, 8'h11});
        @(negedge clk);
        bus.in_valid = '0;
      end
      wait_handshake(20, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL wrap_timeout[%0d]: got no output, expected sel=%0d", n, sb[0].sel);
      end else begin
        exp_item = sb.pop_front();
        if ({bus.out_sel, bus.out_data} !== exp_item) begin
          errors++;
          $display("[TB] FAIL wrap_order[%0d]: got sel=%0d data=%h, expected %0d %h",
                   n, bus.out_sel, bus.out_data, exp_item.sel, exp_item.data);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    int sent = 0;
    int got = 0;
    int last_cyc = -1;
    sb.delete();
    for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
      if (bus.out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_extra: got sel=%0d data=%h, expected no word", bus.out_sel, bus.out_data);
        end else begin
          exp_item = sb.pop_front();
          if ({bus.out_sel, bus.out_data} !== exp_item) begin
            errors++;
            $display("[TB] FAIL stream_word[%0d]: got sel=%0d data=%h, expected %0d %h",
                     got, bus.out_sel, bus.out_data, exp_item.sel, exp_item.data);
          end
        end
        if (got > 0) begin
          checks++;
          if (cyc - last_cyc != 2) begin
            errors++;
            $display("[TB] FAIL stream_rate[%0d]: got gap=%0d, expected 2", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      if (sent < 16) begin
        bus.in_valid = 8'h10;
        bus.in_data[4*8 +: 8] = 8'(8'h40 + sent);
        if (bus.in_ready[4]) begin
          sb.push_back(item_t'{3'd4, 8'(8'h40 + sent)});
          sent++;
        end
      end else begin
        bus.in_valid = '0;
      end
      @(negedge clk);
    end
    bus.in_valid = '0;
    checks++;
    if (got != 16) begin
      errors++;
      $display("[TB] FAIL stream_count: got %0d words, expected 16", got);
    end
  endtask

  task automatic test_reset_mid();
    bit stale = 1'b0;
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 8'h1F;
    for (int i = 0; i < 5; i++) bus.in_data[i*8 +: 8] = 8'(8'hA0 + i);
    @(negedge clk);
    bus.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 8'hE1 || bus.out_data !== 8'hA0) begin
      errors++;
      $display("[TB] FAIL mid_setup: got valid=%b ready=%h data=%h, expected 1 e1 a0",
               bus.out_valid, bus.in_ready, bus.out_data);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel} !== {8'hFF, 1'b0, 8'h00, 3'd0}) begin
      errors++;
      $display("[TB] FAIL mid_async_reset: got ready=%h valid=%b data=%h sel=%0d, expected ff 0 00 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 8'h40;
    bus.in_data[6*8 +: 8] = 8'h6C;
    sb.push_back(item_t'{3'd6, 8'h6C});
    @(negedge clk);
    bus.in_valid = '0;
    wait_handshake(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL mid_timeout: got no output, expected sel=6 data=6c");
    end else begin
      exp_item = sb.pop_front();
      if ({bus.out_sel, bus.out_data} !== exp_item) begin
        errors++;
        $display("[TB] FAIL mid_word: got sel=%0d data=%h, expected %0d %h",
                 bus.out_sel, bus.out_data, exp_item.sel, exp_item.data);
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("[TB] FAIL mid_stale: got extra output after reset, expected none");
    end
  endtask

  initial begin
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_continuous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tdm_mux_8x1.md
# tdm_mux_8x1

Eight-channel time-division collector: the return-path counterpart of the 1-to-8 demultiplexer tree. It accepts words from eight independent source channels and serializes them onto one output stream. Each output word carries a 3-bit channel tag in the same select encoding the demultiplexer consumes, so the stream can be routed back to eight sinks. Each channel has a one-entry holding register, a round-robin arbiter picks among full channels, and the output uses a valid/ready handshake.

## Interface
- DATA_W, default 8: width of each channel word.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk upstream.
- in_valid  input  8  per-channel valid; bit i belongs to channel i.
- in_data  input  8*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  8  per-channel ready; equals NOT full[i].
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  forwarded word.
- out_sel  output  3  source channel index of out_data (0..7).
- out_ready  input  1  downstream accepts when high together with out_valid.

## Operation
- **Channel holding registers:**
  - A channel accepts when in_valid[i] and in_ready[i] are both high. The word is stored and full[i] is set.
  - in_ready[i] is combinational from full[i] only. It never depends on out_ready.
  - A channel emptied by the arbiter in cycle N is ready again after edge N. It cannot accept and release in the same cycle.
- **Output register:**
  - Loads when it is empty, or when out_valid and out_ready are both high (drain and reload in the same cycle).
  - On load, the arbiter grants one full channel. That channel's word and index go to out_data/out_sel, and its full flag is cleared.
  - If no channel is full at load time, out_valid goes low.
- **Arbitration:**
  - Round-robin over channels 0..7.
  - Search starts at last_grant+1 and wraps 7→0.
  - last_grant updates only on an actual grant.
- **Hold rule:** while out_valid=1 and out_ready=0, out_data and out_sel stay stable, and no grant occurs.
- **Reset:**
  - Async assertion clears every full flag and out_valid.
  - last_grant is set to 7, so channel 0 wins the first arbitration.
  - Words in flight are discarded.
  - Reset outputs: in_ready=8'hFF, out_valid=0, out_data=0, out_sel=0.
  - The data registers need no reset. Out_data is still forced to 0 for determinism.

## Timing
- **Latency:** handshake at edge E on an idle block, then out_valid=1 after edge E+1. This is one cycle of holding plus one output register.
- **Throughput:** one word per cycle while out_ready=1 and at least one other channel is full.
- **Per-channel rate:** a single busy channel sustains one word every 2 cycles, because of the ready-after-release rule above.
- **Simultaneous events:**
  - Accepts on several channels in one cycle are all taken.
  - A grant and a new accept on different channels in the same cycle are independent.
- **Fairness:** with all 8 channels continuously full and out_ready=1, each channel is granted exactly once per 8 cycles.
- **Bounded wait:** no channel waits more than 7 grants once it is full.

## Structure
- **Shared package tdm_pkg:**
  - NUM_CH=8
  - CH_W=3
  - a channel-index typedef. The demultiplexer side uses the same typedef for its select.
- **Sub-module rr_arbiter_8:**
  - Inputs: request vector (full flags), advance enable, clk, rst_n.
  - Outputs: one-hot grant, encoded index, grant-valid.
  - Holds the last_grant pointer.
  - It is the only sequential logic besides the holding and output registers.
- The top level holds the eight holding registers, the output register and the handshake glue.

## Test plan
- **Reset:** reset, then a single word 8'hA5 on channel 3 with out_ready=1 → out_valid after one further edge, out_data=8'hA5, out_sel=3; in_ready[3] low for exactly one cycle.
- **Round-robin order:** fill channels 0..7 with values 8'h10..8'h17 in one cycle, then hold out_ready=1 → eight consecutive outputs with out_sel 0,1,..,7 and data 8'h10..8'h17; out_valid drops on the ninth cycle.
- **Backpressure:** channels 2 and 5 full, out_ready=0 for 4 cycles → out_sel=2 and out_data stay stable and in_ready[5] stays low; after out_ready rises, channel 5 is delivered on the next cycle.
- **Wrap-around:** last grant=6, channels 1 and 7 full → channel 7 is granted first, then 1.
- **Continuous load:** channel 4 alone streams 16 words with in_valid=1 and out_ready=1 → 16 words in order at one word per 2 cycles, none lost or duplicated.
- **Reset mid-operation:** assert rst_n=0 with 5 channels full and out_valid=1 → all outputs at reset values immediately, before any clk edge; after release, a new word on channel 6 is delivered with out_sel=6 and no stale data.
